// File: rtl/simd_pkg.sv
// ----------------------------------------------------------------------------
// simd_pkg
// Shared constants for the SIMD ALU lanes.
//   OP_ALU / FN_DIV : opcode/function pair that selects the divide operation.
//   div_state_e     : state encoding of the iterative divider FSM.
//   SAT_MAX/SAT_MIN : saturation limits for the default 32-bit lane width.
// ----------------------------------------------------------------------------
package simd_pkg;

   localparam logic [3:0] OP_ALU = 4'b0000;
   localparam logic [3:0] FN_DIV = 4'b0100;

   localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] SAT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } div_state_e;

endpackage : simd_pkg

// File: rtl/div_sat_clamp.sv
// ----------------------------------------------------------------------------
// div_sat_clamp
// Combinational post-processing for a sign-magnitude quotient: optional
// round-half-away-from-zero, sign application, and clamp to a signed
// BIT_WIDTH result. Usable by any lane producing an unsigned magnitude.
// Build option: SIMD_DIV_ROUND_EN enables rounding from the remainder.
// Ports:
//   mag_i      unsigned quotient magnitude, 2*BIT_WIDTH bits
//   neg_i      result is negative
//   rem_i      division remainder (only used when rounding)
//   div_mag_i  divisor magnitude (only used when rounding)
//   data_o     signed, clamped result
//   sat_o      result was clamped
// ----------------------------------------------------------------------------
module div_sat_clamp #(
   parameter int BIT_WIDTH = 32
) (
   input  logic [2*BIT_WIDTH-1:0] mag_i,
   input  logic                   neg_i,
   input  logic [BIT_WIDTH-1:0]   rem_i,
   input  logic [BIT_WIDTH-1:0]   div_mag_i,
   output logic [BIT_WIDTH-1:0]   data_o,
   output logic                   sat_o
);

   localparam int W = BIT_WIDTH;

   localparam logic [W-1:0] MAX_W = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MIN_W = {1'b1, {(W-1){1'b0}}};

   // Largest representable magnitudes: 2^(W-1)-1 positive, 2^(W-1) negative.
   localparam logic [2*W:0] POS_LIM = {{(W+2){1'b0}}, {(W-1){1'b1}}};
   localparam logic [2*W:0] NEG_LIM = {{(W+1){1'b0}}, 1'b1, {(W-1){1'b0}}};

   // One extra bit so a rounding increment can never wrap.
   logic [2*W:0] mag_r;

`ifdef SIMD_DIV_ROUND_EN
   // Divisor magnitude is at most 2^(W-1), so 2*rem fits in W+1 bits.
   logic round_up;
   assign round_up = ({rem_i, 1'b0} >= {1'b0, div_mag_i});
   assign mag_r    = {1'b0, mag_i} + {{(2*W){1'b0}}, round_up};
`else
   logic unused_round;
   assign unused_round = ^{rem_i, div_mag_i};
   assign mag_r        = {1'b0, mag_i};
`endif

   always_comb begin
      sat_o  = 1'b0;
      data_o = mag_r[W-1:0];
      if (neg_i) begin
         if (mag_r > NEG_LIM) begin
            data_o = MIN_W;
            sat_o  = 1'b1;
         end else begin
            // Magnitude exactly 2^(W-1) negates onto itself, which is MIN.
            data_o = -mag_r[W-1:0];
         end
      end else if (mag_r > POS_LIM) begin
         data_o = MAX_W;
         sat_o  = 1'b1;
      end
   end

endmodule : div_sat_clamp

// File: rtl/simd_div_unit.sv
// ----------------------------------------------------------------------------
// simd_div_unit
// Iterative signed fixed-point divider lane: data_in0 / data_in1 in Q-format
// with saturation. Restoring division, one quotient bit per cycle.
// Build option: SIMD_DIV_ROUND_EN (round half away from zero in FIX).
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   opcode, fn           operation select, captured on accept
//   data_in0, data_in1   signed dividend / divisor
//   src1/2_integer_bits  integer bits of dividend / divisor format
//   in_valid, in_ready   request handshake (ready only when idle)
//   data_out, out_valid  result and its valid, held until out_ready
//   out_ready            consumer accepts the result
//   sat_flag, dz_flag    result clamped / divisor was zero
// Latency: out_valid rises 2*BIT_WIDTH+2 edges after accept for a division,
// 1 edge after accept for divide-by-zero and pass-through.
// ----------------------------------------------------------------------------
module simd_div_unit
   import simd_pkg::*;
#(
   parameter int OPCODE_BITS   = 4,
   parameter int FUNCTION_BITS = 4,
   parameter int BIT_WIDTH     = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [OPCODE_BITS-1:0]   opcode,
   input  logic [FUNCTION_BITS-1:0] fn,
   input  logic [BIT_WIDTH-1:0]     data_in0,
   input  logic [BIT_WIDTH-1:0]     data_in1,
   input  logic [7:0]               src1_integer_bits,
   input  logic [7:0]               src2_integer_bits,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [BIT_WIDTH-1:0]     data_out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     sat_flag,
   output logic                     dz_flag
);

   localparam int W     = BIT_WIDTH;
   localparam int CNT_W = $clog2(2*W);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2*W-1);
   localparam logic [W-1:0]     MAX_W    = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]     MIN_W    = {1'b1, {(W-1){1'b0}}};

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2*W-1:0]   quo_q, quo_d;     // dividend shifting out, quotient shifting in
   logic [W-1:0]     rem_q, rem_d;
   logic [W-1:0]     bmag_q, bmag_d;
   logic             neg_q, neg_d;
   logic [W-1:0]     data_q, data_d;
   logic             valid_q, valid_d;
   logic             sat_q, sat_d;
   logic             dz_q, dz_d;

   // Operand decode at the accepting edge
   logic           is_div;
   logic           a_neg, b_neg, b_zero;
   logic [W-1:0]   a_mag, b_mag;
   logic [7:0]     max_ib, f_shift;
   logic [2*W-1:0] dividend;

   assign is_div   = (opcode == OPCODE_BITS'(OP_ALU)) && (fn == FUNCTION_BITS'(FN_DIV));
   assign a_neg    = data_in0[W-1];
   assign b_neg    = data_in1[W-1];
   assign b_zero   = (data_in1 == '0);
   // Two's-complement negate of MIN yields 2^(W-1), correct as unsigned.
   assign a_mag    = a_neg ? -data_in0 : data_in0;
   assign b_mag    = b_neg ? -data_in1 : data_in1;
   assign max_ib   = (src1_integer_bits > src2_integer_bits) ? src1_integer_bits
                                                             : src2_integer_bits;
   // Formats with no fractional bits degrade to plain integer division.
   assign f_shift  = (max_ib >= 8'(W)) ? 8'd0 : (8'(W) - max_ib);
   assign dividend = {{W{1'b0}}, a_mag} << f_shift;

   // One restoring step. The partial remainder stays below the divisor
   // magnitude (<= 2^(W-1)), so the W-bit subtraction cannot lose bits.
   logic [W:0]   rem_sh;
   logic [W-1:0] rem_sub;
   logic         step_ge;

   assign rem_sh  = {rem_q, quo_q[2*W-1]};
   assign step_ge = (rem_sh >= {1'b0, bmag_q});
   assign rem_sub = rem_sh[W-1:0] - bmag_q;

   logic [W-1:0] fix_data;
   logic         fix_sat;

   div_sat_clamp #(
      .BIT_WIDTH (W)
   ) u_clamp (
      .mag_i     (quo_q),
      .neg_i     (neg_q),
      .rem_i     (rem_q),
      .div_mag_i (bmag_q),
      .data_o    (fix_data),
      .sat_o     (fix_sat)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      bmag_d  = bmag_q;
      neg_d   = neg_q;
      data_d  = data_q;
      valid_d = valid_q;
      sat_d   = sat_q;
      dz_d    = dz_q;

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               sat_d = 1'b0;
               dz_d  = 1'b0;
               if (!is_div) begin
                  data_d  = data_in0;
                  state_d = ST_DONE;
               end else if (b_zero) begin
                  data_d  = a_neg ? MIN_W : MAX_W;
                  sat_d   = 1'b1;
                  dz_d    = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  quo_d   = dividend;
                  rem_d   = '0;
                  bmag_d  = b_mag;
                  neg_d   = a_neg ^ b_neg;
                  cnt_d   = '0;
                  state_d = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            rem_d = step_ge ? rem_sub : rem_sh[W-1:0];
            quo_d = {quo_q[2*W-2:0], step_ge};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            data_d  = fix_data;
            sat_d   = fix_sat;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            // First DONE cycle only raises out_valid, so data_out is already
            // stable when valid appears and short ops keep a one-edge latency.
            if (!valid_q) begin
               valid_d = 1'b1;
            end else if (out_ready) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         bmag_q  <= '0;
         neg_q   <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         sat_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         bmag_q  <= bmag_d;
         neg_q   <= neg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         sat_q   <= sat_d;
         dz_q    <= dz_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE) && !reset;
   assign data_out  = data_q;
   assign out_valid = valid_q;
   assign sat_flag  = sat_q;
   assign dz_flag   = dz_q;

endmodule : simd_div_unit
